// File: rtl/frame_serializer_pkg.sv
// Shared definitions for the frame serializer: width-mode encodings, FSM state
// type, default geometry and a small mode-decoding helper.
package frame_serializer_pkg;

  // Default geometry: 32 data bits plus 8 tag bits.
  localparam int FRAME_W_DEF = 40;
  localparam int CNT_W_DEF   = 6;

  // Width-mode encodings, shared with the datapath counters.
  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] MODE_X1A  = 2'b01;
  localparam logic [1:0] MODE_X1B  = 2'b10;
  localparam logic [1:0] MODE_X2   = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Mode 11 is the only two-bit-per-beat encoding; 01 and 10 both mean one bit.
  function automatic logic is_x2(input logic [1:0] mode);
    return (mode == MODE_X2);
  endfunction

endpackage

// File: rtl/frame_serializer_if.sv
// Frame input and serial beat output bundle for frame_serializer.
// Handshake rule, both sides: a transfer happens on a rising clock edge where
// valid and ready are both high; while valid is high and ready is low the
// sender holds every payload signal stable.
interface frame_serializer_if
  import frame_serializer_pkg::*;
#(
  parameter int FRAME_W = FRAME_W_DEF
);
  logic               frame_valid_i;
  logic               frame_ready_o;
  logic [FRAME_W-1:0] frame_data_i;
  logic [1:0]         width_mode_i;
  logic               ser_valid_o;
  logic               ser_ready_i;
  logic [1:0]         ser_data_o;
  logic [1:0]         ser_nbits_o;
  logic               ser_last_o;

  // Serializer side.
  modport slave (
    input  frame_valid_i, frame_data_i, width_mode_i, ser_ready_i,
    output frame_ready_o, ser_valid_o, ser_data_o, ser_nbits_o, ser_last_o
  );

  // Frame producer / beat consumer side.
  modport master (
    output frame_valid_i, frame_data_i, width_mode_i, ser_ready_i,
    input  frame_ready_o, ser_valid_o, ser_data_o, ser_nbits_o, ser_last_o
  );
endinterface

// File: rtl/frame_serializer_step_counter.sv
// Bit-position counter that advances by 1 or 2 per enabled cycle and flags the
// final step of a frame. Two-step mode drops to a single step when only one
// bit remains (odd-length tail).
module ser_step_counter
  import frame_serializer_pkg::*;
#(
  parameter int FRAME_W = FRAME_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [1:0]       i_mode,
  output logic [CNT_W-1:0] o_pos,
  output logic [1:0]       o_step,
  output logic             o_end
);

  localparam logic [CNT_W-1:0] TAIL_POS = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W:0]   END_SUM  = (CNT_W + 1)'(FRAME_W);

  logic [CNT_W-1:0] r_pos;
  logic [1:0]       w_step;
  logic [CNT_W:0]   w_sum;

  // Step size and end flag from current position and mode.
  always_comb begin
    w_step = 2'd1;
    if (is_x2(i_mode) && (r_pos != TAIL_POS)) begin
      w_step = 2'd2;
    end
    w_sum = {1'b0, r_pos} + {{(CNT_W - 1){1'b0}}, w_step};
  end

  // Position register: cleared on reset or new frame, wraps to 0 after the end step.
  always_ff @(posedge clk) begin
    if (rst || i_load) begin
      r_pos <= '0;
    end else if (i_en) begin
      if (w_sum >= END_SUM) begin
        r_pos <= '0;
      end else begin
        r_pos <= w_sum[CNT_W-1:0];
      end
    end
  end

  assign o_pos  = r_pos;
  assign o_step = w_step;
  assign o_end  = (w_sum >= END_SUM);

endmodule

// File: rtl/frame_serializer.sv
// Parallel-to-serial stage: accepts one FRAME_W-bit frame and emits it LSB first
// as 1- or 2-bit beats. The width mode is captured per frame at accept.
// Optional feature macro: FRAME_SERIALIZER_PARITY_EN adds ser_parity_o, the XOR
// of the accepted frame, shown only alongside the last beat.
module frame_serializer
  import frame_serializer_pkg::*;
#(
  parameter int FRAME_W = FRAME_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  frame_serializer_if.slave bus,
  output logic              busy_o,
  output logic [CNT_W-1:0]  cnt_o,
  output state_t            state_o
`ifdef FRAME_SERIALIZER_PARITY_EN
  ,
  output logic              ser_parity_o
`endif
);

  state_t             r_state;
  state_t             w_state_nx;
  logic [FRAME_W-1:0] r_shift;
  logic [1:0]         r_mode;

  logic               w_in_shift;
  logic               w_xfer;
  logic               w_accept;
  logic [CNT_W-1:0]   w_pos;
  logic [1:0]         w_step;
  logic               w_end;

  assign w_in_shift = (r_state == SHIFT);
  assign w_xfer     = w_in_shift & bus.ser_ready_i;

  // A new frame can enter when idle, or in the cycle the last beat leaves so
  // that consecutive frames run without a bubble. Mode 00 is never accepted.
  assign bus.frame_ready_o = (!w_in_shift | (w_end & w_xfer)) &
                             (bus.width_mode_i != MODE_IDLE);
  assign w_accept = bus.frame_valid_i & bus.frame_ready_o;

  ser_step_counter #(
    .FRAME_W (FRAME_W),
    .CNT_W   (CNT_W)
  ) u_step_counter (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_accept),
    .i_en   (w_xfer),
    .i_mode (r_mode),
    .o_pos  (w_pos),
    .o_step (w_step),
    .o_end  (w_end)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // FSM next state: leave SHIFT after the last beat unless a new frame loads.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_nx = SHIFT;
      end
      SHIFT: begin
        if (w_xfer && w_end) w_state_nx = w_accept ? SHIFT : IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // Beat outputs: only driven while a frame is in flight; the upper bit is
  // masked to 0 on single-bit beats.
  always_comb begin
    bus.ser_valid_o = 1'b0;
    bus.ser_data_o  = 2'b00;
    bus.ser_nbits_o = 2'd0;
    bus.ser_last_o  = 1'b0;
    if (w_in_shift) begin
      bus.ser_valid_o = 1'b1;
      bus.ser_nbits_o = w_step;
      bus.ser_last_o  = w_end;
      if (w_step == 2'd2) begin
        bus.ser_data_o = r_shift[1:0];
      end else begin
        bus.ser_data_o = {1'b0, r_shift[0]};
      end
    end
  end

  // Shift register: load on accept, otherwise consume the bits of each sent beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift <= '0;
    end else if (w_accept) begin
      r_shift <= bus.frame_data_i;
    end else if (w_xfer) begin
      r_shift <= r_shift >> w_step;
    end
  end

  // Width mode captured per frame; later changes on the input are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode <= MODE_IDLE;
    end else if (w_accept) begin
      r_mode <= bus.width_mode_i;
    end
  end

`ifdef FRAME_SERIALIZER_PARITY_EN
  logic r_parity;

  // Frame parity captured at accept, exposed only with the last beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_parity <= 1'b0;
    end else if (w_accept) begin
      r_parity <= ^bus.frame_data_i;
    end
  end

  assign ser_parity_o = r_parity & w_in_shift & w_end;
`endif

  assign busy_o  = w_in_shift;
  assign cnt_o   = w_pos;
  assign state_o = r_state;

endmodule

// File: tb/tb_frame_serializer.sv
// Bench for frame_serializer: a 40-bit and a 7-bit instance driven with
// directed and random frames; beats are predicted from the frame contents and
// compared by negedge monitors.
module tb_frame_serializer;
  import frame_serializer_pkg::*;

`ifdef FRAME_SERIALIZER_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  localparam int EW = 12; // {pos[5:0], last, nbits[1:0], data[1:0], parity}

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   rdy_rand = 1'b0;

  int total = 0;
  int bad   = 0;
  int pop40 = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp7_q[$];

  frame_serializer_if #(.FRAME_W(40)) bus ();
  frame_serializer_if #(.FRAME_W(7))  bus7 ();

  logic       busy40, busy7;
  logic [5:0] cnt40;
  logic [2:0] cnt7;
  state_t     st40, st7;
  logic       par40, par7;

  frame_serializer #(.FRAME_W(40), .CNT_W(6)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .busy_o  (busy40),
    .cnt_o   (cnt40),
    .state_o (st40)
`ifdef FRAME_SERIALIZER_PARITY_EN
    ,
    .ser_parity_o (par40)
`endif
  );

  frame_serializer #(.FRAME_W(7), .CNT_W(3)) dut7 (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus7),
    .busy_o  (busy7),
    .cnt_o   (cnt7),
    .state_o (st7)
`ifdef FRAME_SERIALIZER_PARITY_EN
    ,
    .ser_parity_o (par7)
`endif
  );

`ifndef FRAME_SERIALIZER_PARITY_EN
  assign par40 = 1'b0;
  assign par7  = 1'b0;
`endif

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit reached, act=running req=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%0h req=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Reference model: split a frame into beats from the width rules alone.
  task automatic model_push(input logic [39:0] d, input int fw, input logic [1:0] m,
                            input bit s7);
    int            pos = 0;
    int            n;
    logic          par = 1'b0;
    logic          last;
    logic [1:0]    bd;
    logic [EW-1:0] e;
    for (int i = 0; i < fw; i++) par = par ^ d[i];
    while (pos < fw) begin
      n    = (m == 2'b11 && pos + 1 < fw) ? 2 : 1;
      bd   = (n == 2) ? {d[pos+1], d[pos]} : {1'b0, d[pos]};
      last = (pos + n >= fw);
      e    = {6'(pos), last, 2'(n), bd, PAR_ON & last & par};
      if (s7) exp7_q.push_back(e);
      else    exp_q.push_back(e);
      pos += n;
    end
  endtask

  // Driver: offer a frame, wait for acceptance, then model it.
  task automatic send(input logic [39:0] d, input logic [1:0] m, input bit s7);
    int   n = 0;
    logic rdy;
    if (s7) begin
      bus7.frame_valid_i = 1'b1; bus7.frame_data_i = d[6:0]; bus7.width_mode_i = m;
    end else begin
      bus.frame_valid_i = 1'b1; bus.frame_data_i = d; bus.width_mode_i = m;
    end
    @(negedge clk);
    rdy = s7 ? bus7.frame_ready_o : bus.frame_ready_o;
    while (!rdy && n < 500) begin
      n++;
      @(negedge clk);
      rdy = s7 ? bus7.frame_ready_o : bus.frame_ready_o;
    end
    if (!rdy) begin
      total++; bad++;
      $display("FAIL accept_timeout act=0 req=1 t=%0t", $time);
    end
    @(posedge clk);
    if (rdy) model_push(d, s7 ? 7 : 40, m, s7);
    #1;
    // Drop valid and scramble the mode: neither may disturb the frame in flight.
    if (s7) begin
      bus7.frame_valid_i = 1'b0; bus7.width_mode_i = 2'($urandom_range(0, 3));
    end else begin
      bus.frame_valid_i = 1'b0; bus.width_mode_i = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || exp7_q.size() != 0) && n < 3000) begin
      n++;
      @(posedge clk);
    end
    if (exp_q.size() != 0 || exp7_q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout act=%0d req=0", exp_q.size() + exp7_q.size());
    end
    #1;
  endtask

  // Downstream ready: steady 1 or random per cycle.
  initial begin
    bus.ser_ready_i  = 1'b1;
    bus7.ser_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.ser_ready_i  = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      bus7.ser_ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor for the 40-bit instance: compare against the head of the queue
  // every cycle (stalled beats must hold), pop on transfer.
  always @(negedge clk) begin : mon40
    logic [EW-1:0] act, req;
    logic          exp_rdy;
    if (!rst) begin
      act = {cnt40, bus.ser_last_o, bus.ser_nbits_o, bus.ser_data_o, par40};
      req = (exp_q.size() != 0) ? exp_q[0] : '0;
      exp_rdy = ((exp_q.size() == 0) || (exp_q.size() == 1 && bus.ser_ready_i)) &&
                (bus.width_mode_i != 2'b00);
      chk("beat40", 64'(act), 64'(req));
      chk("valid40", 64'(bus.ser_valid_o), 64'(exp_q.size() != 0));
      chk("busy40", 64'(busy40), 64'(exp_q.size() != 0));
      chk("ready40", 64'(bus.frame_ready_o), 64'(exp_rdy));
      if (bus.ser_valid_o && bus.ser_ready_i && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        pop40++;
      end
    end
  end

  // Monitor for the 7-bit instance.
  always @(negedge clk) begin : mon7
    logic [EW-1:0] act, req;
    logic          exp_rdy;
    if (!rst) begin
      act = {3'b000, cnt7, bus7.ser_last_o, bus7.ser_nbits_o, bus7.ser_data_o, par7};
      req = (exp7_q.size() != 0) ? exp7_q[0] : '0;
      exp_rdy = ((exp7_q.size() == 0) || (exp7_q.size() == 1 && bus7.ser_ready_i)) &&
                (bus7.width_mode_i != 2'b00);
      chk("beat7", 64'(act), 64'(req));
      chk("valid7", 64'(bus7.ser_valid_o), 64'(exp7_q.size() != 0));
      chk("busy7", 64'(busy7), 64'(exp7_q.size() != 0));
      chk("ready7", 64'(bus7.frame_ready_o), 64'(exp_rdy));
      if (bus7.ser_valid_o && bus7.ser_ready_i && exp7_q.size() != 0) begin
        void'(exp7_q.pop_front());
      end
    end
  end

  // Main sequence.
  initial begin
    int start;
    int n;
    bus.frame_valid_i  = 1'b0; bus.frame_data_i  = '0; bus.width_mode_i  = 2'b00;
    bus7.frame_valid_i = 1'b0; bus7.frame_data_i = '0; bus7.width_mode_i = 2'b00;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(bus.ser_valid_o), 64'd0);
    chk("rst_busy", 64'(busy40), 64'd0);
    chk("rst_cnt", 64'(cnt40), 64'd0);
    chk("rst_last", 64'(bus.ser_last_o), 64'd0);
    chk("rst_par", 64'(par40), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // x1 single frame, then x2 single frame, steady ready.
    send(40'h00_0000_0005, 2'b01, 1'b0);
    wait_drain();
    send(40'hA5_DEAD_BEEF, 2'b11, 1'b0);
    wait_drain();

    // Mode 00 never accepted.
    bus.frame_valid_i = 1'b1; bus.frame_data_i = 40'h12_3456_789A; bus.width_mode_i = 2'b00;
    repeat (6) @(posedge clk);
    #1;
    bus.frame_valid_i = 1'b0;

    // Odd-length tail on the 7-bit instance.
    send(40'h55, 2'b11, 1'b1);
    wait_drain();

    // Back-to-back with random backpressure and random modes.
    rdy_rand = 1'b1;
    for (int i = 0; i < 12; i++) begin
      send({8'($urandom), 32'($urandom)}, 2'($urandom_range(1, 3)), 1'b0);
    end
    wait_drain();
    for (int i = 0; i < 10; i++) begin
      send(40'($urandom), 2'($urandom_range(1, 3)), 1'b1);
    end
    wait_drain();
    rdy_rand = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Reset mid-frame at beat 10.
    start = pop40;
    send({8'($urandom), 32'($urandom)}, 2'b11, 1'b0);
    n = 0;
    while (pop40 < start + 10 && n < 200) begin
      n++;
      @(posedge clk);
    end
    #1;
    rst = 1'b1;
    bus.width_mode_i = 2'b01;
    @(posedge clk);
    exp_q.delete();
    exp7_q.delete();
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 64'(bus.ser_valid_o), 64'd0);
    chk("midrst_busy", 64'(busy40), 64'd0);
    chk("midrst_cnt", 64'(cnt40), 64'd0);
    chk("midrst_ready", 64'(bus.frame_ready_o), 64'd1);
    @(posedge clk); #1;

    // Parity frame and a final mixed pair.
    send(40'h00_0000_0001, 2'b01, 1'b0);
    send(40'h80_0000_0003, 2'b10, 1'b0);
    wait_drain();
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_serializer.md
Name: frame_serializer

Overview:
Parallel-to-serial stage for the iterative datapath. Accepts one FRAME_W-bit frame (32 data + 8 tag bits by default) over a valid/ready handshake and emits it LSB-first as 1-bit or 2-bit beats. The width mode is chosen per frame. An internal bit-position step counter runs in the same 1-step/2-step mode encoding the datapath counters use, and its end flag terminates the frame.

Parameters:
FRAME_W, 40, frame length in bits (32 data + 8 tag); any value >= 2, odd allowed
CNT_W, 6, bit-position counter width; must satisfy 2^CNT_W > FRAME_W

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  synchronous, active-high reset
frame_valid_i  in  1  upstream frame offered
frame_ready_o  out  1  frame accepted this cycle when valid & ready
frame_data_i  in  FRAME_W  frame payload, bit 0 sent first
width_mode_i  in  2  00 = reject, 01/10 = 1 bit/beat, 11 = 2 bits/beat; sampled at accept
ser_valid_o  out  1  beat valid
ser_ready_i  in  1  downstream accepts beat
ser_data_o  out  2  beat bits; bit0 = lower frame bit; bit1 = 0 when nbits = 1
ser_nbits_o  out  2  valid bits in beat: 1 or 2
ser_last_o  out  1  final beat of frame
busy_o  out  1  frame in flight
cnt_o  out  CNT_W  current bit position (debug/observability)

Behaviour:
- States: IDLE, SHIFT. Reset -> IDLE. pos_r = 0, shift_r = 0, mode_r = 00. All outputs 0 except frame_ready_o, which is combinational.
- frame_ready_o = (IDLE | (SHIFT & ser_last_o & ser_ready_i)) & (width_mode_i != 00). Mode 00 never accepts, so the frame stalls upstream.
- Accept: load shift_r <= frame_data_i, mode_r <= width_mode_i, pos_r <= 0, state <= SHIFT. The first beat is valid the next cycle (1-cycle latency).
- In SHIFT: ser_valid_o = 1, ser_data_o = shift_r[1:0] (masked per nbits), busy_o = 1.
- Beat size is 1 for mode 01/10. For mode 11 it is 2, except 1 when pos_r == FRAME_W-1 (odd-length tail).
- ser_last_o = (pos_r + step >= FRAME_W), where step is 1 or 2. This is the end condition of a 1/2-step counter: precise end at FRAME_W-1 (x1) or FRAME_W-2 (x2), overflow end at FRAME_W-1 (x2).
- Transfer (ser_valid_o & ser_ready_i): shift_r >>= step, pos_r += step. On the last beat, pos_r <= 0 and state goes to IDLE, unless a new frame is accepted in the same cycle (back-to-back, no bubble), in which case state stays in SHIFT with the new load.
- Stall (ser_ready_i = 0): all beat outputs and state hold; no change of data while valid is high.
- width_mode_i changing mid-frame has no effect; mode_r governs until the last beat.
- rst mid-frame: frame discarded, no ser_last_o emitted, back to IDLE next cycle.
- Beat count: x1 = FRAME_W beats; x2 = ceil(FRAME_W/2) beats.

Optional Feature:
- Macro: FRAME_SERIALIZER_PARITY_EN.
- Defined:
  - Adds output ser_parity_o (1 bit), the even parity (XOR) of the accepted frame.
  - Computed at accept and registered.
  - Valid only alongside ser_last_o; 0 at all other times and after reset.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package frame_serializer_pkg holds:
  - mode encodings MODE_IDLE = 2'b00, MODE_X1A = 2'b01, MODE_X1B = 2'b10, MODE_X2 = 2'b11
  - state typedef {IDLE, SHIFT}
  - default FRAME_W/CNT_W constants
- One natural sub-module: ser_step_counter.
  - Holds the bit-position counter, with clear/load, mode-driven 1/2 increment, and end flag.
  - Enabled only on beat transfer.
- Handshake and shift register stay in the top module.

Test Plan:
- x1 single frame: mode 01, data 40'h00_0000_0005, ser_ready_i = 1 -> first valid beat one cycle after accept, bits 1,0,1,0,... for 40 beats, ser_last_o only on beat 40, frame_ready_o high in the final beat cycle.
- x2 single frame: mode 11, data 40'hA5_DEAD_BEEF -> 20 beats, beat0 ser_data_o = 2'b11, nbits = 2 on every beat, last on beat 20.
- Odd length: FRAME_W = 7, mode 11, data 7'h55 -> 4 beats, data 01, 01, 01, 1 with nbits 2, 2, 2, 1, last on beat 4.
- Backpressure and back-to-back: ser_ready_i toggles 1 0 0 1. Outputs hold through stalls. A second frame held valid is accepted in the last-beat cycle, and its beat 0 follows with no idle cycle.
- Mode 00 and mid-frame change: frame_valid_i = 1 with mode 00 -> frame_ready_o stays 0. Switching 11 to 01 mid-frame leaves the beat count at 20.
- Reset mid-frame: assert rst at beat 10 -> next cycle ser_valid_o = 0, busy_o = 0, cnt_o = 0, frame_ready_o follows the mode rule. With FRAME_SERIALIZER_PARITY_EN, frame 40'h1 gives ser_parity_o = 1 on the last beat.
